// File: rtl/mdu_defs.sv
// Shared multiply/divide definitions: instruction classes, MDU op codes,
// default latencies. Used by the decoder, the stall unit and mdu_ctrl.
package mdu_defs;

   typedef enum logic [2:0] {
      IT_ALU    = 3'd0,
      IT_LOAD   = 3'd1,
      IT_STORE  = 3'd2,
      IT_BRANCH = 3'd3,
      IT_JUMP   = 3'd4,
      IT_MDU    = 3'd5,
      IT_SYS    = 3'd6,
      IT_RSVD   = 3'd7
   } instrType_e;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } mduOp_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } mduState_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   function automatic logic isMduOp(input logic [2:0] op);
      return (op != OP_NONE) && (op != OP_RSVD);
   endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide unit: fixed-latency busy window in front of the
// stall unit, results parked in pending registers until the count expires.
module mdu_ctrl
   import mdu_defs::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic        cancel,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = $clog2(DIV_CYCLES + 1);

   mduState_e     stateQ, stateNxt;
   logic [CW-1:0] cntQ, cntNxt;
   logic          busyQ, busyNxt;
   logic [31:0]   hiQ, hiNxt;
   logic [31:0]   loQ, loNxt;
   logic [31:0]   pendHiQ, pendHiNxt;
   logic [31:0]   pendLoQ, pendLoNxt;
   logic          pendOkQ, pendOkNxt;

   logic          accept;
   logic          divZero;
   logic [63:0]   mulS;
   logic [63:0]   mulU;
   logic [32:0]   dvdS;
   logic [32:0]   dvsS;
   logic [31:0]   quoS;
   logic [31:0]   remS;
   logic [31:0]   dvsU;
   logic [31:0]   quoU;
   logic [31:0]   remU;

   assign accept  = start && !cancel && (stateQ == MD_IDLE) && isMduOp(op);
   assign divZero = (rt_val == 32'd0);

   assign mulS = $signed({{32{rs_val[31]}}, rs_val})
               * $signed({{32{rt_val[31]}}, rt_val});
   assign mulU = {32'd0, rs_val} * {32'd0, rt_val};

   // 33-bit signed operands keep 0x80000000 / -1 from overflowing
   assign dvdS = {rs_val[31], rs_val};
   assign dvsS = divZero ? 33'd1 : {rt_val[31], rt_val};
   assign quoS = 32'($signed(dvdS) / $signed(dvsS));
   assign remS = 32'($signed(dvdS) % $signed(dvsS));

   assign dvsU = divZero ? 32'd1 : rt_val;
   assign quoU = rs_val / dvsU;
   assign remU = rs_val % dvsU;

   always_comb begin
      stateNxt  = stateQ;
      cntNxt    = cntQ;
      busyNxt   = busyQ;
      hiNxt     = hiQ;
      loNxt     = loQ;
      pendHiNxt = pendHiQ;
      pendLoNxt = pendLoQ;
      pendOkNxt = pendOkQ;
      unique case (stateQ)
         MD_IDLE: begin
            if (accept) begin
               unique case (mduOp_e'(op))
                  OP_MULT: begin
                     pendHiNxt = mulS[63:32];
                     pendLoNxt = mulS[31:0];
                     pendOkNxt = 1'b1;
                     cntNxt    = CW'(MULT_CYCLES);
                     stateNxt  = MD_BUSY;
                     busyNxt   = 1'b1;
                  end
                  OP_MULTU: begin
                     pendHiNxt = mulU[63:32];
                     pendLoNxt = mulU[31:0];
                     pendOkNxt = 1'b1;
                     cntNxt    = CW'(MULT_CYCLES);
                     stateNxt  = MD_BUSY;
                     busyNxt   = 1'b1;
                  end
                  OP_DIV: begin
                     pendHiNxt = remS;
                     pendLoNxt = quoS;
                     pendOkNxt = !divZero;
                     cntNxt    = CW'(DIV_CYCLES);
                     stateNxt  = MD_BUSY;
                     busyNxt   = 1'b1;
                  end
                  OP_DIVU: begin
                     pendHiNxt = remU;
                     pendLoNxt = quoU;
                     pendOkNxt = !divZero;
                     cntNxt    = CW'(DIV_CYCLES);
                     stateNxt  = MD_BUSY;
                     busyNxt   = 1'b1;
                  end
                  OP_MTHI: hiNxt = rs_val;
                  OP_MTLO: loNxt = rs_val;
                  default: ;
               endcase
            end
         end
         MD_BUSY: begin
            // start and cancel are deliberately ignored while in flight
            if (cntQ <= CW'(1)) begin
               cntNxt   = '0;
               stateNxt = MD_IDLE;
               busyNxt  = 1'b0;
               if (pendOkQ) begin
                  hiNxt = pendHiQ;
                  loNxt = pendLoQ;
               end
            end else begin
               cntNxt = cntQ - CW'(1);
            end
         end
         default: begin
            stateNxt = MD_IDLE;
            busyNxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ  <= MD_IDLE;
         cntQ    <= '0;
         busyQ   <= 1'b0;
         hiQ     <= '0;
         loQ     <= '0;
         pendHiQ <= '0;
         pendLoQ <= '0;
         pendOkQ <= 1'b0;
      end else begin
         stateQ  <= stateNxt;
         cntQ    <= cntNxt;
         busyQ   <= busyNxt;
         hiQ     <= hiNxt;
         loQ     <= loNxt;
         pendHiQ <= pendHiNxt;
         pendLoQ <= pendLoNxt;
         pendOkQ <= pendOkNxt;
      end
   end

   assign busy = busyQ;
   assign hi   = hiQ;
   assign lo   = loQ;

endmodule
